// File: rtl/seven_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
package seven_pkg;

    localparam int CODE_W = 3;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_W = MAX_DIGITS * CODE_W;
    localparam logic [CODE_W-1:0] BLANK_CODE = 3'b000;

    // Pull digit k out of a packed code vector (digit 0 in the LSBs).
    function automatic logic [CODE_W-1:0] digit_code(input logic [MAX_W-1:0] vec,
                                                     input logic [2:0] k);
        return vec[k*CODE_W +: CODE_W];
    endfunction

endpackage

// File: rtl/seven_scan_tick.sv
// Per-digit slot timer: counts PRESCALE cycles while enabled and flags the
// last cycle of each slot.
module scan_tick #(
    parameter int PRESCALE = 1000,
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);
    assign cnt  = cnt_q;

    // Next count: wrap on tick, advance while enabled, otherwise hold.
    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_scan.sv
// Time-multiplexed scan controller feeding one shared seven-segment decoder.
// Display contents are double-buffered and swapped only at frame boundaries.
// Optional feature: define SEVEN_SCAN_BLANK_EN to blank the digit enables for
// the first BLANK_CYCLES cycles of every slot (anti-ghosting).
module seven_scan
    import seven_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic [CODE_W*DIGITS-1:0] din,
    output logic [CODE_W-1:0]        code,
    output logic [DIGITS-1:0]        an,
    output logic                     pend,
    output logic                     frame
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = CODE_W * DIGITS;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK_CYCLES);

    logic          tick;
    logic [CW-1:0] cnt;
    logic          boundary;
    logic          blank;

    logic [IW-1:0]     idx_q,   idx_d;
    logic [DW-1:0]     disp_q,  disp_d;
    logic [DW-1:0]     pbuf_q,  pbuf_d;
    logic              pend_q,  pend_d;
    logic [CODE_W-1:0] code_q,  code_d;
    logic [DIGITS-1:0] an_q,    an_d;
    logic              frame_q, frame_d;

    scan_tick #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick),
        .cnt  (cnt)
    );

`ifdef SEVEN_SCAN_BLANK_EN
    assign blank = (cnt < BLANK_C);
`else
    logic unused_blank;
    assign unused_blank = (cnt < BLANK_C);
    assign blank = 1'b0;
`endif

    // Next index, buffer swap and registered outputs from the post-edge state.
    always_comb begin
        boundary = tick && (idx_q == LAST_IDX);
        idx_d    = idx_q;
        if (tick) begin
            idx_d = boundary ? '0 : idx_q + 1'b1;
        end

        pbuf_d = load ? din : pbuf_q;
        disp_d = disp_q;
        pend_d = pend_q;
        if (boundary) begin
            pend_d = 1'b0;
            if (load) begin
                disp_d = din;
            end else if (pend_q) begin
                disp_d = pbuf_q;
            end
        end else if (load) begin
            pend_d = 1'b1;
        end

        code_d  = digit_code(MAX_W'(disp_d), 3'(idx_d));
        an_d    = DIGITS'(1) << idx_d;
        frame_d = boundary;
    end

    // State and output registers; reset discards both buffers.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            disp_q  <= '0;
            pbuf_q  <= '0;
            pend_q  <= 1'b0;
            code_q  <= BLANK_CODE;
            an_q    <= DIGITS'(1);
            frame_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pbuf_q  <= pbuf_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign code  = code_q;
    assign an    = (en && !blank) ? an_q : '0;
    assign pend  = pend_q;
    assign frame = frame_q;

endmodule
